// File: rtl/vx_wb_pkg.sv
// rtl/vx_wb_pkg.sv - writeback codes, default lane/warp widths and arbiter state encodings
package vx_wb_pkg;

   localparam logic [1:0] WB_NO  = 2'd0;
   localparam logic [1:0] WB_ALU = 2'd1;
   localparam logic [1:0] WB_MEM = 2'd2;
   localparam logic [1:0] WB_JAL = 2'd3;

   localparam int VX_NT      = 4;
   localparam int VX_NW_BITS = 1;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_MEM_PRI   = 2'd1,
      ARB_EXE_FORCE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/vx_wb_fifo.sv
// rtl/vx_wb_fifo.sv - generic DEPTH x WIDTH synchronous FIFO with full/empty flags
module vx_wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // Flags come from registered occupancy only, so a pop never frees a slot in its own cycle
   assign o_full     = (r_count == CW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign w_push     = i_push && !o_full;
   assign w_pop      = i_pop && !o_empty;
   assign o_pop_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/vx_writeback.sv
// rtl/vx_writeback.sv - merges execute/memory results into one registered register-file write
// Optional VX_WB_PERF_EN adds saturating write and execute-stall counters.
module vx_writeback
   import vx_wb_pkg::*;
#(
   parameter int NT             = VX_NT,
   parameter int NW_BITS        = VX_NW_BITS,
   parameter int EXE_FIFO_DEPTH = 2,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_exe_valid,
   output logic                in_exe_ready,
   input  logic [1:0]          in_exe_wb,
   input  logic [4:0]          in_exe_rd,
   input  logic [NT*32-1:0]    in_exe_alu_result,
   input  logic [31:0]         in_exe_PC_next,
   input  logic [NT-1:0]       in_exe_thread_valid,
   input  logic [NW_BITS-1:0]  in_exe_warp_num,
   input  logic                in_mem_valid,
   output logic                in_mem_ready,
   input  logic [4:0]          in_mem_rd,
   input  logic [NT*32-1:0]    in_mem_data,
   input  logic [NT-1:0]       in_mem_thread_valid,
   input  logic [NW_BITS-1:0]  in_mem_warp_num,
   output logic [NT*32-1:0]    out_write_data,
   output logic [4:0]          out_rd,
   output logic [1:0]          out_wb,
   output logic [NT-1:0]       out_wb_valid,
   output logic [NW_BITS-1:0]  out_wb_warp_num
`ifdef VX_WB_PERF_EN
   ,
   output logic [31:0]         out_perf_writes,
   output logic [31:0]         out_perf_exe_stall
`endif
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int EW = 2 + 5 + NT*32 + 32 + NT + NW_BITS;

   logic [EW-1:0]      w_fifo_din;
   logic [EW-1:0]      w_fifo_dout;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic               w_exe_push;
   logic [1:0]         w_head_wb;
   logic [4:0]         w_head_rd;
   logic [NT*32-1:0]   w_head_alu;
   logic [31:0]        w_head_pc;
   logic [NT-1:0]      w_head_mask;
   logic [NW_BITS-1:0] w_head_warp;
   logic               w_head_writes;

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [SW-1:0]      r_starve;
   logic [SW-1:0]      w_starve_nxt;
   logic               w_grant_mem;
   logic               w_grant_exe;

   logic [NT*32-1:0]   r_out_data;
   logic [4:0]         r_out_rd;
   logic [1:0]         r_out_wb;
   logic [NT-1:0]      r_out_valid;
   logic [NW_BITS-1:0] r_out_warp;

   assign in_exe_ready = !reset && !w_fifo_full;
   assign w_exe_push   = in_exe_valid && in_exe_ready;
   assign w_fifo_din   = {in_exe_wb, in_exe_rd, in_exe_alu_result, in_exe_PC_next,
                          in_exe_thread_valid, in_exe_warp_num};
   assign {w_head_wb, w_head_rd, w_head_alu, w_head_pc, w_head_mask, w_head_warp} = w_fifo_dout;

   // A WB_MEM code arriving on the execute path has no data to write, so it becomes a bubble
   assign w_head_writes = ((w_head_wb == WB_ALU) || (w_head_wb == WB_JAL)) && (w_head_rd != 5'd0);

   vx_wb_fifo #(
      .DEPTH (EXE_FIFO_DEPTH),
      .WIDTH (EW)
   ) u_exe_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_exe_push),
      .i_push_data (w_fifo_din),
      .i_pop       (w_grant_exe),
      .o_pop_data  (w_fifo_dout),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ARB_IDLE;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve;
      w_grant_mem  = 1'b0;
      w_grant_exe  = 1'b0;
      if (!reset) begin
         if (r_state == ARB_EXE_FORCE) begin
            w_grant_exe = !w_fifo_empty;
         end else if (in_mem_valid) begin
            w_grant_mem = 1'b1;
         end else begin
            w_grant_exe = !w_fifo_empty;
         end
      end
      // Starvation is only counted while execute work is actually waiting
      if (w_grant_exe) begin
         w_starve_nxt = '0;
         w_state_nxt  = ARB_MEM_PRI;
      end else if (w_grant_mem) begin
         if (!w_fifo_empty) w_starve_nxt = r_starve + 1'b1;
         w_state_nxt = (w_starve_nxt == SW'(STARVE_LIMIT)) ? ARB_EXE_FORCE : ARB_MEM_PRI;
      end else begin
         w_state_nxt = ARB_IDLE;
      end
   end

   assign in_mem_ready = w_grant_mem;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_data  <= '0;
         r_out_rd    <= '0;
         r_out_wb    <= WB_NO;
         r_out_valid <= '0;
         r_out_warp  <= '0;
      end else begin
         r_out_wb    <= WB_NO;
         r_out_valid <= '0;
         if (w_grant_mem) begin
            r_out_data <= in_mem_data;
            r_out_rd   <= in_mem_rd;
            r_out_warp <= in_mem_warp_num;
            if (in_mem_rd != 5'd0) begin
               r_out_wb    <= WB_MEM;
               r_out_valid <= in_mem_thread_valid;
            end
         end else if (w_grant_exe) begin
            r_out_data <= (w_head_wb == WB_JAL) ? {NT{w_head_pc}} : w_head_alu;
            r_out_rd   <= w_head_rd;
            r_out_warp <= w_head_warp;
            if (w_head_writes) begin
               r_out_wb    <= w_head_wb;
               r_out_valid <= w_head_mask;
            end
         end
      end
   end

   assign out_write_data  = r_out_data;
   assign out_rd          = r_out_rd;
   assign out_wb          = r_out_wb;
   assign out_wb_valid    = r_out_valid;
   assign out_wb_warp_num = r_out_warp;

`ifdef VX_WB_PERF_EN
   logic [31:0] r_perf_writes;
   logic [31:0] r_perf_exe_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_writes    <= '0;
         r_perf_exe_stall <= '0;
      end else begin
         if ((r_out_wb != WB_NO) && (r_perf_writes != '1))
            r_perf_writes <= r_perf_writes + 32'd1;
         if (in_exe_valid && !in_exe_ready && (r_perf_exe_stall != '1))
            r_perf_exe_stall <= r_perf_exe_stall + 32'd1;
      end
   end

   assign out_perf_writes    = r_perf_writes;
   assign out_perf_exe_stall = r_perf_exe_stall;
`endif

endmodule

// File: tb/tb_vx_writeback.sv
// tb/tb_vx_writeback.sv - scoreboard bench for vx_writeback with directed execute/memory vectors
module tb_vx_writeback;
   import vx_wb_pkg::*;

   localparam int NT  = 4;
   localparam int NWB = 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_exe_valid;
   logic              in_exe_ready;
   logic [1:0]        in_exe_wb;
   logic [4:0]        in_exe_rd;
   logic [NT*32-1:0]  in_exe_alu_result;
   logic [31:0]       in_exe_PC_next;
   logic [NT-1:0]     in_exe_thread_valid;
   logic [NWB-1:0]    in_exe_warp_num;
   logic              in_mem_valid;
   logic              in_mem_ready;
   logic [4:0]        in_mem_rd;
   logic [NT*32-1:0]  in_mem_data;
   logic [NT-1:0]     in_mem_thread_valid;
   logic [NWB-1:0]    in_mem_warp_num;
   logic [NT*32-1:0]  out_write_data;
   logic [4:0]        out_rd;
   logic [1:0]        out_wb;
   logic [NT-1:0]     out_wb_valid;
   logic [NWB-1:0]    out_wb_warp_num;
`ifdef VX_WB_PERF_EN
   logic [31:0]       perf_writes;
   logic [31:0]       perf_exe_stall;
`endif

   typedef struct packed {
      logic [1:0]       wb;
      logic [4:0]       rd;
      logic [NT*32-1:0] data;
      logic [NT-1:0]    mask;
      logic [NWB-1:0]   warp;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;

   vx_writeback dut (
      .clk                 (clk),
      .reset               (reset),
      .in_exe_valid        (in_exe_valid),
      .in_exe_ready        (in_exe_ready),
      .in_exe_wb           (in_exe_wb),
      .in_exe_rd           (in_exe_rd),
      .in_exe_alu_result   (in_exe_alu_result),
      .in_exe_PC_next      (in_exe_PC_next),
      .in_exe_thread_valid (in_exe_thread_valid),
      .in_exe_warp_num     (in_exe_warp_num),
      .in_mem_valid        (in_mem_valid),
      .in_mem_ready        (in_mem_ready),
      .in_mem_rd           (in_mem_rd),
      .in_mem_data         (in_mem_data),
      .in_mem_thread_valid (in_mem_thread_valid),
      .in_mem_warp_num     (in_mem_warp_num),
      .out_write_data      (out_write_data),
      .out_rd              (out_rd),
      .out_wb              (out_wb),
      .out_wb_valid        (out_wb_valid),
      .out_wb_warp_num     (out_wb_warp_num)
`ifdef VX_WB_PERF_EN
      ,
      .out_perf_writes     (perf_writes),
      .out_perf_exe_stall  (perf_exe_stall)
`endif
   );

   function automatic logic [NT*32-1:0] lanes(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] d);
      return {d, c, b, a};
   endfunction

   function automatic logic [NT*32-1:0] rep(input logic [31:0] v);
      return {v, v, v, v};
   endfunction

   task automatic expect_wr(input logic [1:0] wb, input logic [4:0] rd, input logic [NT*32-1:0] d,
                            input logic [NT-1:0] m, input logic [NWB-1:0] w);
      wr_t e;
      e = {wb, rd, d, m, w};
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a negedge; returns at the negedge following acceptance with valid still high
   task automatic exe_send(input logic [1:0] wb, input logic [4:0] rd, input logic [NT*32-1:0] alu,
                           input logic [31:0] pc, input logic [NT-1:0] m, input logic [NWB-1:0] w,
                           output int waits);
      logic acc;
      in_exe_valid = 1'b1;  in_exe_wb = wb;  in_exe_rd = rd;  in_exe_alu_result = alu;
      in_exe_PC_next = pc;  in_exe_thread_valid = m;  in_exe_warp_num = w;
      waits = 0;
      acc   = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
         #1 acc = in_exe_ready;
         @(negedge clk);
         if (!acc) waits++;
      end
      if (!acc) begin
         checks++;  errors++;
         $display("FAIL exe_push_timeout: rd=%0d never accepted, required acceptance within 50 cycles", rd);
      end
   endtask

   task automatic mem_send(input logic [4:0] rd, input logic [NT*32-1:0] d, input logic [NT-1:0] m,
                           input logic [NWB-1:0] w);
      logic acc;
      in_mem_valid = 1'b1;  in_mem_rd = rd;  in_mem_data = d;
      in_mem_thread_valid = m;  in_mem_warp_num = w;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
         #1 acc = in_mem_ready;
         @(negedge clk);
      end
      if (!acc) begin
         checks++;  errors++;
         $display("FAIL mem_accept_timeout: rd=%0d never accepted, required acceptance within 50 cycles", rd);
      end
   endtask

   // Monitor: every issued write must match the head of the scoreboard
   initial begin
      wr_t act;
      wr_t e;
      forever begin
         @(negedge clk);
         if (out_wb != 2'd0) begin
            act = {out_wb, out_rd, out_write_data, out_wb_valid, out_wb_warp_num};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got wb=%0d rd=%0d data=%h mask=%h warp=%0d, required no write",
                        act.wb, act.rd, act.data, act.mask, act.warp);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  errors++;
                  $display("FAIL write_rd%0d: got wb=%0d rd=%0d data=%h mask=%h warp=%0d, required wb=%0d rd=%0d data=%h mask=%h warp=%0d",
                           e.rd, act.wb, act.rd, act.data, act.mask, act.warp,
                           e.wb, e.rd, e.data, e.mask, e.warp);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100000, required completion");
      $fatal(1);
   end

   initial begin
      int w;
      int ew[4];
      reset = 1'b1;
      in_exe_valid = 1'b0;  in_exe_wb = '0;  in_exe_rd = '0;  in_exe_alu_result = '0;
      in_exe_PC_next = '0;  in_exe_thread_valid = '0;  in_exe_warp_num = '0;
      in_mem_valid = 1'b0;  in_mem_rd = '0;  in_mem_data = '0;
      in_mem_thread_valid = '0;  in_mem_warp_num = '0;

      repeat (3) @(negedge clk);
      check("ready_in_reset", in_exe_ready, 0);
      check("reset_out_wb", out_wb, 0);
      check("reset_out_wb_valid", out_wb_valid, 0);
      check("reset_out_rd", out_rd, 0);
      check("reset_out_data", out_write_data, 0);
      reset = 1'b0;
      #1 check("ready_after_reset", in_exe_ready, 1);
      @(negedge clk);

      // Single ALU write
      expect_wr(WB_ALU, 5'd5, lanes(32'h11, 32'h22, 32'h33, 32'h44), 4'hF, 1'b0);
      exe_send(WB_ALU, 5'd5, lanes(32'h11, 32'h22, 32'h33, 32'h44), 32'h0, 4'hF, 1'b0, w);
      in_exe_valid = 1'b0;
      repeat (4) @(negedge clk);

      // JAL writes PC_next on every lane
      expect_wr(WB_JAL, 5'd1, rep(32'h8000_0014), 4'hF, 1'b0);
      exe_send(WB_JAL, 5'd1, rep(32'hDEAD_BEEF), 32'h8000_0014, 4'hF, 1'b0, w);
      in_exe_valid = 1'b0;
      repeat (4) @(negedge clk);

      // rd=0 and NO_WB are bubbles; the rd=2 write between them still issues
      expect_wr(WB_ALU, 5'd2, lanes(32'hA0, 32'hA1, 32'hA2, 32'hA3), 4'h5, 1'b1);
      exe_send(WB_ALU, 5'd0, rep(32'h5555_5555), 32'h0, 4'hF, 1'b0, w);
      exe_send(WB_ALU, 5'd2, lanes(32'hA0, 32'hA1, 32'hA2, 32'hA3), 32'h0, 4'h5, 1'b1, w);
      exe_send(WB_NO, 5'd7, rep(32'h7777_7777), 32'h0, 4'hF, 1'b0, w);
      in_exe_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Back-to-back execute stream with no memory traffic never stalls and keeps order
      for (int i = 0; i < 3; i++)
         expect_wr(WB_ALU, 5'(10 + i), rep(32'hC000_0000 + 32'(i)), 4'hF, 1'(i));
      for (int i = 0; i < 3; i++) begin
         exe_send(WB_ALU, 5'(10 + i), rep(32'hC000_0000 + 32'(i)), 32'h0, 4'hF, 1'(i), ew[i]);
         check($sformatf("b2b_wait_%0d", i), ew[i], 0);
      end
      in_exe_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Memory-only writes, including an rd=0 bubble
      expect_wr(WB_MEM, 5'd9, lanes(32'h9000_0001, 32'h9000_0002, 32'h9000_0003, 32'h9000_0004), 4'hA, 1'b1);
      mem_send(5'd9, lanes(32'h9000_0001, 32'h9000_0002, 32'h9000_0003, 32'h9000_0004), 4'hA, 1'b1);
      mem_send(5'd0, rep(32'h9999_9999), 4'hF, 1'b0);
      in_mem_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Both streams busy: after the first (empty-FIFO) memory grant, 4 memory grants per forced execute
      for (int i = 0; i < 5; i++)  expect_wr(WB_MEM, 5'(i + 1), rep(32'h1000_0000 + 32'(i)), 4'hF, 1'(i));
      expect_wr(WB_ALU, 5'd20, rep(32'h2000_0000), 4'h3, 1'b1);
      for (int i = 5; i < 9; i++)  expect_wr(WB_MEM, 5'(i + 1), rep(32'h1000_0000 + 32'(i)), 4'hF, 1'(i));
      expect_wr(WB_ALU, 5'd21, rep(32'h2000_0001), 4'h3, 1'b1);
      for (int i = 9; i < 13; i++) expect_wr(WB_MEM, 5'(i + 1), rep(32'h1000_0000 + 32'(i)), 4'hF, 1'(i));
      expect_wr(WB_ALU, 5'd22, rep(32'h2000_0002), 4'h3, 1'b1);
      expect_wr(WB_ALU, 5'd23, rep(32'h2000_0003), 4'h3, 1'b1);
      fork
         begin
            for (int i = 0; i < 13; i++)
               mem_send(5'(i + 1), rep(32'h1000_0000 + 32'(i)), 4'hF, 1'(i));
            in_mem_valid = 1'b0;
         end
         begin
            for (int j = 0; j < 4; j++)
               exe_send(WB_ALU, 5'(20 + j), rep(32'h2000_0000 + 32'(j)), 32'h0, 4'h3, 1'b1, ew[j]);
            in_exe_valid = 1'b0;
         end
      join
      check("starve_wait_e0", ew[0], 0);
      check("starve_wait_e1", ew[1], 0);
      check("starve_wait_e2", ew[2], 4);
      check("starve_wait_e3", ew[3], 4);
      repeat (8) @(negedge clk);

      // Reset with one execute entry buffered: that entry must never be written
      expect_wr(WB_MEM, 5'd3, rep(32'h3333_3333), 4'hF, 1'b0);
      in_mem_valid = 1'b1;  in_mem_rd = 5'd3;  in_mem_data = rep(32'h3333_3333);
      in_mem_thread_valid = 4'hF;  in_mem_warp_num = 1'b0;
      in_exe_valid = 1'b1;  in_exe_wb = WB_ALU;  in_exe_rd = 5'd4;  in_exe_alu_result = rep(32'h4444_4444);
      in_exe_thread_valid = 4'hF;  in_exe_warp_num = 1'b0;
      #1 check("pre_reset_mem_ready", in_mem_ready, 1);
      check("pre_reset_exe_ready", in_exe_ready, 1);
      @(negedge clk);
      in_exe_valid = 1'b0;
      reset = 1'b1;
      #1 check("mid_reset_exe_ready", in_exe_ready, 0);
      check("mid_reset_mem_ready", in_mem_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      in_mem_valid = 1'b0;
      check("post_reset_out_wb", out_wb, 0);
      check("post_reset_out_wb_valid", out_wb_valid, 0);
      #1 check("post_reset_exe_ready", in_exe_ready, 1);
      repeat (6) @(negedge clk);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
